mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D cache to physical-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache, D-cache) arbiter in front of a single cacheline adapter.
// One transaction at a time; ties go to the side not served last.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_addr,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_addr,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,

  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  arb_state_t        state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  pmem_op_t          hold_op_q, hold_op_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [LINE_W-1:0] hold_wdata_q, hold_wdata_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;

  logic i_pend;
  logic d_pend;
  logic serving;

  assign i_pend  = i_pmem_read;
  assign d_pend  = d_pmem_read | d_pmem_write;
  assign serving = (state_q != ARB_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_op_d    = hold_op_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    i_cnt_d      = i_cnt_q;
    d_cnt_d      = d_cnt_q;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (i_pend && (!d_pend || last_grant_q == GRANT_D)) begin
          state_d      = ARB_SERVE_I;
          hold_op_d    = OP_READ;
          hold_addr_d  = i_pmem_addr;
          hold_wdata_d = '0;
        end else if (d_pend) begin
          // A simultaneous D read and write-back: the write-back goes first.
          state_d      = ARB_SERVE_D;
          hold_op_d    = d_pmem_write ? OP_WRITE : OP_READ;
          hold_addr_d  = d_pmem_addr;
          hold_wdata_d = d_pmem_wdata;
        end
      end

      ARB_SERVE_I: begin
        if (pmem_resp) begin
          i_pmem_resp  = 1'b1;
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_I;
          i_cnt_d      = sat_inc(i_cnt_q);
        end
      end

      ARB_SERVE_D: begin
        if (pmem_resp) begin
          d_pmem_resp  = 1'b1;
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_D;
          d_cnt_d      = sat_inc(d_cnt_q);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // Memory-side request comes only from the hold registers, never from the live inputs.
  assign pmem_read  = serving && (hold_op_q == OP_READ);
  assign pmem_write = serving && (hold_op_q == OP_WRITE);
  assign pmem_addr  = hold_addr_q;
  assign pmem_wdata = hold_wdata_q;

  assign i_pmem_rdata = (state_q == ARB_SERVE_I) ? pmem_rdata : '0;
  assign d_pmem_rdata = (state_q == ARB_SERVE_D) ? pmem_rdata : '0;

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values; the hold
    // registers are reset as well so pmem_addr/pmem_wdata read zero out of reset.
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_I;
      hold_op_q    <= OP_READ;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_op_q    <= hold_op_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      i_cnt_q      <= i_cnt_d;
      d_cnt_q      <= d_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_addr;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_addr;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  i_grant_cnt;
  logic [15:0]  d_grant_cnt;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pmem_read  (i_pmem_read),
    .i_pmem_addr  (i_pmem_addr),
    .i_pmem_rdata (i_pmem_rdata),
    .i_pmem_resp  (i_pmem_resp),
    .d_pmem_read  (d_pmem_read),
    .d_pmem_write (d_pmem_write),
    .d_pmem_addr  (d_pmem_addr),
    .d_pmem_wdata (d_pmem_wdata),
    .d_pmem_rdata (d_pmem_rdata),
    .d_pmem_resp  (d_pmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_addr    (pmem_addr),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .i_grant_cnt  (i_grant_cnt),
    .d_grant_cnt  (d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: which side (0 none, 1 I, 2 D) owns memory, what it asked for,
  // who was served last, and plain integer completion counts.
  int           m_serving;
  int           m_last;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  bit           m_write;
  int           m_icnt;
  int           m_dcnt;

  task automatic model_reset();
    m_serving = 0;
    m_last    = 1;
    m_addr    = '0;
    m_wdata   = '0;
    m_write   = 1'b0;
    m_icnt    = 0;
    m_dcnt    = 0;
  endtask

  task automatic model_update();
    int win;
    if (rst) begin
      model_reset();
    end else if (m_serving == 0) begin
      bit ip = i_pmem_read;
      bit dp = d_pmem_read || d_pmem_write;
      if (ip && dp)  win = (m_last == 1) ? 2 : 1;
      else if (ip)   win = 1;
      else if (dp)   win = 2;
      else           win = 0;
      if (win == 1) begin
        m_serving = 1; m_addr = i_pmem_addr; m_wdata = '0; m_write = 1'b0;
      end else if (win == 2) begin
        m_serving = 2; m_addr = d_pmem_addr; m_wdata = d_pmem_wdata; m_write = d_pmem_write;
      end
    end else if (pmem_resp) begin
      if (m_serving == 1) begin
        if (m_icnt < 65535) m_icnt++;
      end else begin
        if (m_dcnt < 65535) m_dcnt++;
      end
      m_last    = m_serving;
      m_serving = 0;
    end
  endtask

  logic         obs_pmem_read, obs_pmem_write, obs_i_resp, obs_d_resp;
  logic [31:0]  obs_pmem_addr;
  logic [255:0] obs_pmem_wdata, obs_i_rdata, obs_d_rdata;
  logic [15:0]  obs_i_cnt, obs_d_cnt;
  int           grant_log[$];

  // One clock cycle: inputs are already driven; compare outputs, advance model, wait.
  task automatic step();
    #1;
    obs_pmem_read  = pmem_read;
    obs_pmem_write = pmem_write;
    obs_pmem_addr  = pmem_addr;
    obs_pmem_wdata = pmem_wdata;
    obs_i_resp     = i_pmem_resp;
    obs_d_resp     = d_pmem_resp;
    obs_i_rdata    = i_pmem_rdata;
    obs_d_rdata    = d_pmem_rdata;
    obs_i_cnt      = i_grant_cnt;
    obs_d_cnt      = d_grant_cnt;
    if (obs_i_resp === 1'b1) grant_log.push_back(1);
    if (obs_d_resp === 1'b1) grant_log.push_back(2);

    check("pmem_read",  obs_pmem_read,  (m_serving != 0) && !m_write);
    check("pmem_write", obs_pmem_write, (m_serving != 0) && m_write);
    if (m_serving != 0) begin
      check("pmem_addr",  obs_pmem_addr,  m_addr);
      check("pmem_wdata", obs_pmem_wdata, m_wdata);
    end
    check("i_resp",  obs_i_resp,  (m_serving == 1) && pmem_resp);
    check("d_resp",  obs_d_resp,  (m_serving == 2) && pmem_resp);
    check("i_rdata", obs_i_rdata, (m_serving == 1) ? pmem_rdata : 256'd0);
    check("d_rdata", obs_d_rdata, (m_serving == 2) ? pmem_rdata : 256'd0);
    check("i_cnt",   obs_i_cnt,   m_icnt);
    check("d_cnt",   obs_d_cnt,   m_dcnt);

    model_update();
    @(negedge clk);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    i_pmem_read  = 1'b0;
    d_pmem_read  = 1'b0;
    d_pmem_write = 1'b0;
    pmem_resp    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int rd_cycles;
    int resp_pulses;
    int budget;
    logic [255:0] line;
    logic [255:0] wline;

    rst          = 1'b1;
    i_pmem_addr  = '0;
    d_pmem_addr  = '0;
    d_pmem_wdata = '0;
    pmem_rdata   = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Out of reset: every output zero.
    step();
    check("reset_pmem_addr",  obs_pmem_addr,  0);
    check("reset_pmem_wdata", obs_pmem_wdata, 0);

    // Single I fill at 0x60 with memory answering in the sixth serve cycle.
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_0060;
    step();
    line = rand_line();
    pmem_rdata = line;
    rd_cycles = 0;
    resp_pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      pmem_resp = (c == 6);
      step();
      rd_cycles   += int'(obs_pmem_read);
      resp_pulses += int'(obs_i_resp);
      check("t037_addr", obs_pmem_addr, 32'h60);
      if (c == 6) check("t037_rdata", obs_i_rdata, line);
    end
    idle_inputs();
    step();
    check("t037_read_cycles", rd_cycles, 6);
    check("t037_resp_pulses", resp_pulses, 1);
    check("t037_i_cnt", obs_i_cnt, 1);
    check("t037_idle_read", obs_pmem_read, 0);

    // Simultaneous I read and D write after reset: D wins, idle gap, then I.
    do_reset();
    wline = rand_line();
    i_pmem_read  = 1'b1; i_pmem_addr = 32'h0000_1000;
    d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_2000; d_pmem_wdata = wline;
    step();
    step();
    check("t038_d_write", obs_pmem_write, 1);
    check("t038_d_read",  obs_pmem_read, 0);
    check("t038_d_addr",  obs_pmem_addr, 32'h2000);
    check("t038_d_wdata", obs_pmem_wdata, wline);
    pmem_resp = 1'b1;
    step();
    check("t038_d_resp", obs_d_resp, 1);
    check("t038_i_quiet", obs_i_resp, 0);
    d_pmem_write = 1'b0;
    pmem_resp = 1'b0;
    step();
    check("t038_gap", obs_pmem_read | obs_pmem_write, 0);
    step();
    check("t038_i_read", obs_pmem_read, 1);
    check("t038_i_addr", obs_pmem_addr, 32'h1000);
    pmem_resp = 1'b1;
    step();
    check("t038_i_resp", obs_i_resp, 1);
    idle_inputs();
    step();

    // Both sides hold requests continuously: grants alternate starting with D.
    do_reset();
    grant_log.delete();
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    budget = 0;
    while (grant_log.size() < 6 && budget < 300) begin
      i_pmem_addr = $urandom;
      d_pmem_addr = $urandom;
      pmem_rdata  = rand_line();
      pmem_resp   = ($urandom_range(0, 2) == 0);
      step();
      budget++;
    end
    idle_inputs();
    step();
    check("t039_grants", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size() && k < 6; k++)
      check("t039_order", grant_log[k], (k % 2 == 0) ? 2 : 1);
    check("t039_i_cnt", obs_i_cnt, 3);
    check("t039_d_cnt", obs_d_cnt, 3);

    // Reset two cycles into an I service, with counters non-zero beforehand.
    i_pmem_read = 1'b1;
    i_pmem_addr = 32'h0000_0300;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("t041_pre_rst_read", obs_pmem_read, 1);
    rst = 1'b0;
    i_pmem_read = 1'b0;
    pmem_resp = 1'b1;
    step();
    check("t041_read_dropped", obs_pmem_read, 0);
    check("t041_late_resp", obs_i_resp, 0);
    check("t041_i_cnt", obs_i_cnt, 0);
    check("t041_d_cnt", obs_d_cnt, 0);
    check("t041_addr", obs_pmem_addr, 0);
    pmem_resp = 1'b0;
    step();
    check("t041_i_cnt_after", obs_i_cnt, 0);

    // D address changes mid-service; the latched address must hold.
    d_pmem_read = 1'b1;
    d_pmem_addr = 32'h0000_0100;
    step();
    d_pmem_addr = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t040_addr_hold", obs_pmem_addr, 32'h100);
    end
    pmem_resp = 1'b1;
    step();
    check("t040_addr_resp", obs_pmem_addr, 32'h100);
    check("t040_d_resp", obs_d_resp, 1);
    idle_inputs();
    step();

    // Saturation: counter pinned at all-ones, one more D completion.
    force dut.d_cnt_q = 16'hFFFF;
    m_dcnt = 65535;
    step();
    release dut.d_cnt_q;
    d_pmem_write = 1'b1;
    d_pmem_addr  = 32'h0000_0400;
    d_pmem_wdata = rand_line();
    step();
    pmem_resp = 1'b1;
    step();
    check("t042_d_resp", obs_d_resp, 1);
    idle_inputs();
    step();
    check("t042_d_cnt_sat", obs_d_cnt, 16'hFFFF);

    // Random traffic with occasional resets and idle-time memory responses.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      i_pmem_read  = $urandom_range(0, 1);
      d_pmem_read  = ($urandom_range(0, 2) == 0);
      d_pmem_write = ($urandom_range(0, 3) == 0);
      i_pmem_addr  = $urandom;
      d_pmem_addr  = $urandom;
      d_pmem_wdata = rand_line();
      pmem_rdata   = rand_line();
      pmem_resp    = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
